// File: rtl/mul_wb_unit_if.sv
// Operand, control and register-bank write-port bundle for mul_wb_unit.
// master drives requests and ALU writebacks; slave is the unit itself.
interface mul_wb_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              start;
   logic              signed_op;
   logic              hi_sel;
   logic [DATA_W-1:0] opA;
   logic [DATA_W-1:0] opB;
   logic [ADDR_W-1:0] dst;
   logic              alu_we;
   logic [ADDR_W-1:0] alu_wrA;
   logic [DATA_W-1:0] alu_wrD;
   logic              busy;
   logic              done;
   logic              RgW;
   logic [ADDR_W-1:0] wrA;
   logic [DATA_W-1:0] wrD;

   modport master (
      output start, signed_op, hi_sel, opA, opB, dst, alu_we, alu_wrA, alu_wrD,
      input  busy, done, RgW, wrA, wrD
   );

   modport slave (
      input  start, signed_op, hi_sel, opA, opB, dst, alu_we, alu_wrA, alu_wrD,
      output busy, done, RgW, wrA, wrD
   );
endinterface

// File: rtl/mul_wb_unit.sv
// Sign-magnitude shift-add multiplier, one multiplier bit per cycle, feeding the
// register bank write port behind single-cycle ALU writebacks.
module mul_wb_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic          clock,
   input  logic          rst,
   mul_wb_unit_if.slave  bus
);
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

   state_t              state;
   logic                busy_r;
   logic                sign_r;
   logic                hi_r;
   logic [ADDR_W-1:0]   dst_r;
   logic [2*DATA_W-1:0] mcand;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   mplr;
   logic [CW-1:0]       count;

   logic                a_neg, b_neg, last;
   logic [DATA_W-1:0]   mag_a_in, mag_b_in;
   logic [2*DATA_W-1:0] acc_step;

   // Most-negative input negates to itself, which is the right unsigned magnitude.
   assign a_neg    = bus.signed_op & bus.opA[DATA_W-1];
   assign b_neg    = bus.signed_op & bus.opB[DATA_W-1];
   assign mag_a_in = a_neg ? -bus.opA : bus.opA;
   assign mag_b_in = b_neg ? -bus.opB : bus.opB;
   assign acc_step = mplr[0] ? acc + mcand : acc;
   assign last     = (count == CW'(DATA_W - 1));

   always_ff @(posedge clock) begin
      if (rst) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         sign_r <= 1'b0;
         hi_r   <= 1'b0;
         dst_r  <= '0;
         mcand  <= '0;
         acc    <= '0;
         mplr   <= '0;
         count  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               sign_r <= a_neg ^ b_neg;
               hi_r   <= bus.hi_sel;
               dst_r  <= bus.dst;
               mcand  <= {{DATA_W{1'b0}}, mag_a_in};
               mplr   <= mag_b_in;
               acc    <= '0;
               count  <= '0;
               busy_r <= 1'b1;
               state  <= RUN;
            end
            RUN: begin
               // The shifting multiplicand stands in for magA<<count.
               acc   <= (last && sign_r) ? -acc_step : acc_step;
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               count <= count + CW'(1);
               if (last) state <= WB;
            end
            WB: if (!bus.alu_we) begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic              rgw_c, done_c;
   logic [ADDR_W-1:0] wra_c;
   logic [DATA_W-1:0] wrd_c;

   // rst gates the pending multiply write in the very cycle reset is asserted.
   always_comb begin
      rgw_c  = 1'b0;
      done_c = 1'b0;
      wra_c  = '0;
      wrd_c  = '0;
      if (bus.alu_we) begin
         rgw_c = 1'b1;
         wra_c = bus.alu_wrA;
         wrd_c = bus.alu_wrD;
      end else if (state == WB && !rst) begin
         rgw_c  = 1'b1;
         done_c = 1'b1;
         wra_c  = dst_r;
         wrd_c  = hi_r ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0];
      end
   end

   assign bus.RgW  = rgw_c;
   assign bus.done = done_c;
   assign bus.wrA  = wra_c;
   assign bus.wrD  = wrd_c;
   assign bus.busy = busy_r;
endmodule

// File: doc/mul_wb_unit.md
Name: mul_wb_unit

Overview:
Multi-cycle shift-add multiplier plus register-bank writeback arbiter. It sits directly upstream of the register bank write port (RgW/wrA/wrD).
- Takes operands already read from register bank ports A/B.
- Computes a 64-bit product over DATA_W cycles.
- Writes the selected half into the destination register.
- Passes single-cycle ALU writebacks through with priority.

Parameters:
DATA_W, 32, operand/result width; product is 2*DATA_W.
ADDR_W, 5, register address width.

Ports:
clock  in  1  system clock, all state updates on rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  launch multiply; sampled only in IDLE.
signed_op  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
hi_sel  in  1  1 = write product[2*DATA_W-1:DATA_W], 0 = write product[DATA_W-1:0]; sampled with start.
opA  in  DATA_W  multiplicand (register bank rdDA).
opB  in  DATA_W  multiplier (register bank rdDB).
dst  in  ADDR_W  destination register; sampled with start.
alu_we  in  1  ALU writeback request.
alu_wrA  in  ADDR_W  ALU destination address.
alu_wrD  in  DATA_W  ALU result.
busy  out  1  high from cycle after accepted start until multiply result is written.
done  out  1  one-cycle pulse in the cycle the multiply result drives the write port.
RgW  out  1  register bank write enable.
wrA  out  ADDR_W  register bank write address.
wrD  out  DATA_W  register bank write data.

Behaviour:
- State machine: IDLE, RUN, WB.
- Reset (synchronous, any state, including mid-RUN/WB):
  - state=IDLE, busy=0, count=0, accumulator/operand registers=0.
  - No pending multiply write survives reset.
  - Write port follows ALU pass-through only (RgW=alu_we).
- IDLE: if start=1, latch sign=signed_op&(opA[MSB]^opB[MSB]), magA=|opA|, magB=|opB| (raw values when unsigned), dst, hi_sel; clear 2*DATA_W accumulator, count=0; go RUN.
- RUN, one multiplier bit per cycle:
  - if magB[0], acc += magA<<count; magB >>= 1; count++.
  - After DATA_W RUN cycles go WB.
  - On WB entry, product = sign ? -acc : acc (2*DATA_W two's complement).
- WB:
  - If alu_we=0: RgW=1, wrA=latched dst, wrD=selected half, done=1; next state IDLE.
  - If alu_we=1: ALU wins; stay WB, done=0; retry next cycle. There is no upper bound on the stall.
- Write-port mux (combinational from registered state and ALU inputs):
  - ALU has priority: if alu_we=1, RgW=1, wrA=alu_wrA, wrD=alu_wrD.
  - Else if state=WB: multiply write as above.
  - Else RgW=0; wrA/wrD are don't-care but driven 0.
- busy is registered:
  - Rises the cycle after an accepted start.
  - Falls the cycle after the WB write (IDLE entry).
- start while busy is ignored; no queueing.
- start in the same cycle as the WB write is ignored, because the unit is not yet in IDLE.
- Latency with no ALU conflict: start accepted at edge T; RUN for edges T+1..T+DATA_W; write visible on the port during the cycle after edge T+DATA_W; register bank captures it at edge T+DATA_W+1.
- Edge cases:
  - Most-negative signed operand: magnitude is 2^(DATA_W-1) in DATA_W bits unsigned; product is correct.
  - dst=0 is written like any other address; register 0 policy belongs to the register bank.

Test Plan:
- Unsigned: opA=0xFFFFFFFF, opB=2, hi_sel=0, dst=10 -> exactly DATA_W+1 cycles after start, one-cycle RgW=1, wrA=10, wrD=0xFFFFFFFE, done=1. Repeat with hi_sel=1 -> wrD=0x00000001.
- Signed: opA=-3, opB=5, signed_op=1. hi_sel=0 -> wrD=0xFFFFFFF1. hi_sel=1 -> wrD=0xFFFFFFFF. Also opA=0x80000000, opB=-1, hi_sel=0 -> wrD=0x80000000.
- Conflict: hold alu_we=1 (wrA=15, wrD=0x3) for 2 cycles covering the WB cycle -> ALU writes appear first, done=0 and busy=1 meanwhile. The multiply write (wrA=dst) follows in the first cycle with alu_we=0.
- Ignored start: pulse start with opA=7 at RUN count 5 -> original result unchanged, no second write, busy drops once.
- Reset mid-RUN at count 12 -> next cycle busy=0, state IDLE. No multiply write ever appears; an ALU write in the following cycle passes straight through.
- Back-to-back: start in the first IDLE cycle after done, with opA=6, opB=7 -> wrD=42 written DATA_W+1 cycles later.
